// File: rtl/muli_pipe_if.sv
// Signal bundle for the muli_pipe tap multiplier: stall, sample and coefficient
// inputs plus the valid-qualified scaled product and sticky overflow outputs.
interface muli_pipe_if #(
  parameter int unsigned N  = 16,
  parameter int unsigned CW = 16
);
  logic          EN;
  logic          R_IN;
  logic [N-1:0]  D_IN;
  logic          C_WE;
  logic [CW-1:0] C_IN;
  logic          OVF_CLR;
  logic          R_OUT;
  logic [N-1:0]  D_OUT;
  logic          OVF;

  // Upstream side: tap delay line / control.
  modport master (
    output EN, R_IN, D_IN, C_WE, C_IN, OVF_CLR,
    input  R_OUT, D_OUT, OVF
  );

  // Multiplier side.
  modport slave (
    input  EN, R_IN, D_IN, C_WE, C_IN, OVF_CLR,
    output R_OUT, D_OUT, OVF
  );
endinterface

// File: rtl/muli_pipe.sv
// Pipelined signed tap multiplier: sample x loadable coefficient, rescaled by an
// arithmetic right shift with optional round-half-up and saturation, and a
// sticky overflow flag. LAT enabled edges from accept to R_OUT.
module muli_pipe #(
  parameter int unsigned N     = 16,
  parameter int unsigned CW    = 16,
  parameter int          I     = 1,
  parameter int unsigned SHIFT = 15,
  parameter int unsigned LAT   = 2,
  parameter int unsigned RND   = 1,
  parameter int unsigned SAT   = 1
) (
  input logic         CLK,
  input logic         RST_N,
  muli_pipe_if.slave  bus
);

  localparam int unsigned PW = N + CW;
  localparam int unsigned RS = (SHIFT > 0) ? SHIFT - 1 : 0;
  // Half-LSB bias of the shifted result; zero when truncating or not shifting.
  localparam logic [PW:0] RBIAS = (RND != 0 && SHIFT > 0) ?
                                  ({{PW{1'b0}}, 1'b1} << RS) : '0;
  localparam logic [N-1:0] SMAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] SMIN = {1'b1, {(N-1){1'b0}}};

  logic [CW-1:0]        coef_q;
  logic signed [PW-1:0] d_ext, c_ext, prod;
  logic signed [PW-1:0] fin_p;
  logic                 fin_v;
  logic signed [PW:0]   sum, q;
  logic [PW:N-1]        q_hi;
  logic                 ovf_c;
  logic [N-1:0]         res;
  logic                 r_out_q;
  logic [N-1:0]         d_out_q;
  logic                 ovf_q, ovf_d;

  // Full-width signed product using the coefficient held before this edge.
  always_comb begin
    d_ext = {{CW{bus.D_IN[N-1]}}, bus.D_IN};
    c_ext = {{N{coef_q[CW-1]}}, coef_q};
    prod  = d_ext * c_ext;
  end

  // Coefficient register; writes act regardless of stall.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      coef_q <= CW'(I);
    end else if (bus.C_WE) begin
      coef_q <= bus.C_IN;
    end
  end

  generate
    if (LAT > 1) begin : g_pipe
      localparam int unsigned NS = LAT - 1;
      logic signed [PW-1:0] p_q [NS];
      logic [NS-1:0]        v_q;

      // Product stage followed by pure {P, valid} delay stages.
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          v_q <= '0;
          for (int i = 0; i < int'(NS); i++) p_q[i] <= '0;
        end else if (bus.EN) begin
          p_q[0] <= prod;
          v_q[0] <= bus.R_IN;
          for (int i = 1; i < int'(NS); i++) begin
            p_q[i] <= p_q[i-1];
            v_q[i] <= v_q[i-1];
          end
        end
      end

      assign fin_p = p_q[NS-1];
      assign fin_v = v_q[NS-1];
    end else begin : g_comb
      // Single-register tap: multiply feeds the output stage directly.
      assign fin_p = prod;
      assign fin_v = bus.R_IN;
    end
  endgenerate

  // Round, shift and range-check; one extra bit keeps the bias add from wrapping.
  always_comb begin
    sum   = {fin_p[PW-1], fin_p} + RBIAS;
    q     = sum >>> SHIFT;
    q_hi  = q[PW:N-1];
    ovf_c = !((&q_hi) || !(|q_hi));
    res   = q[N-1:0];
    if (SAT != 0 && ovf_c) begin
      res = q[PW] ? SMIN : SMAX;
    end
  end

  // Output stage: valid follows every enabled edge, data only on valid exits.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_out_q <= 1'b0;
      d_out_q <= '0;
    end else if (bus.EN) begin
      r_out_q <= fin_v;
      if (fin_v) begin
        d_out_q <= res;
      end
    end
  end

  // Sticky overflow next state: clear first so a same-edge set wins.
  always_comb begin
    ovf_d = ovf_q;
    if (bus.OVF_CLR) begin
      ovf_d = 1'b0;
    end
    if (bus.EN && fin_v && ovf_c) begin
      ovf_d = 1'b1;
    end
  end

  // Overflow flag register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.R_OUT = r_out_q;
  assign bus.D_OUT = d_out_q;
  assign bus.OVF   = ovf_q;

endmodule

// File: tb/tb_muli_pipe.sv
// Bench for muli_pipe: five builds share one stimulus (LAT2/RND1/SAT1,
// RND0, SAT0, LAT4, LAT1) and are checked against hand-computed values.
module tb_muli_pipe;

  localparam int NDUT = 5;
  localparam int unsigned LAT_T [NDUT] = '{2, 2, 2, 4, 1};
  localparam int unsigned RND_T [NDUT] = '{1, 0, 1, 1, 1};
  localparam int unsigned SAT_T [NDUT] = '{1, 1, 0, 1, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, r_in, c_we, ovf_clr;
  logic [15:0] d_in, c_in;
  logic [NDUT-1:0] r_out, ovf_o;
  logic [15:0] d_out [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    muli_pipe_if #(.N(16), .CW(16)) bus ();
    assign bus.EN      = en;
    assign bus.R_IN    = r_in;
    assign bus.D_IN    = d_in;
    assign bus.C_WE    = c_we;
    assign bus.C_IN    = c_in;
    assign bus.OVF_CLR = ovf_clr;
    assign r_out[g]    = bus.R_OUT;
    assign d_out[g]    = bus.D_OUT;
    assign ovf_o[g]    = bus.OVF;

    muli_pipe #(
      .N(16), .CW(16), .I(1), .SHIFT(15),
      .LAT(LAT_T[g]), .RND(RND_T[g]), .SAT(SAT_T[g])
    ) dut (
      .CLK  (clk),
      .RST_N(rst_n),
      .bus  (bus)
    );
  end

  typedef struct {
    logic [15:0] coef, din, e_rs, e_t, e_w;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic        rin;
    logic [15:0] din;
    logic        r0; logic [15:0] d0;
    logic        r3; logic [15:0] d3;
    logic        r4; logic [15:0] d4;
  } strm_t;

  typedef struct {
    logic        en, rin;
    logic [15:0] din;
    logic        r0;
    logic [15:0] d0;
  } stall_t;

  vec_t   vecs  [8];
  strm_t  strm  [7];
  stall_t stl   [10];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    for (int g = 0; g < NDUT; g++) begin
      chk($sformatf("%s_r_dut%0d", tag, g), {15'b0, r_out[g]}, 16'h0);
      chk($sformatf("%s_d_dut%0d", tag, g), d_out[g], 16'h0);
      chk($sformatf("%s_ovf_dut%0d", tag, g), {15'b0, ovf_o[g]}, 16'h0);
    end
  endtask

  function automatic logic [15:0] exp_of(input vec_t v, input int g);
    if (g == 1) return v.e_t;
    if (g == 2) return v.e_w;
    return v.e_rs;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // coef, din, RND1/SAT1, RND0/SAT1, RND1/SAT0, ovf
    vecs[0] = '{16'h4000, 16'h1000, 16'h0800, 16'h0800, 16'h0800, 1'b0};
    vecs[1] = '{16'h4000, 16'h0003, 16'h0002, 16'h0001, 16'h0002, 1'b0};
    vecs[2] = '{16'h4000, 16'hFFFD, 16'hFFFF, 16'hFFFE, 16'hFFFF, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h7FFF, 16'h7FFE, 16'h7FFE, 16'h7FFE, 1'b0};
    vecs[4] = '{16'h8000, 16'h7FFF, 16'h8001, 16'h8001, 16'h8001, 1'b0};
    vecs[5] = '{16'hC000, 16'h0001, 16'h0000, 16'hFFFF, 16'h0000, 1'b0};
    vecs[6] = '{16'h2000, 16'h0800, 16'h0200, 16'h0200, 16'h0200, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000, 1'b1};

    // rin, din | LAT2 r,d | LAT4 r,d | LAT1 r,d   (coef 0x4000)
    strm[0] = '{1'b1, 16'h1000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0800};
    strm[1] = '{1'b1, 16'h2000, 1'b1, 16'h0800, 1'b0, 16'h0000, 1'b1, 16'h1000};
    strm[2] = '{1'b1, 16'hF000, 1'b1, 16'h1000, 1'b0, 16'h0000, 1'b1, 16'hF800};
    strm[3] = '{1'b0, 16'h0000, 1'b1, 16'hF800, 1'b1, 16'h0800, 1'b0, 16'hF800};
    strm[4] = '{1'b0, 16'h0000, 1'b0, 16'hF800, 1'b1, 16'h1000, 1'b0, 16'hF800};
    strm[5] = '{1'b0, 16'h0000, 1'b0, 16'hF800, 1'b1, 16'hF800, 1'b0, 16'hF800};
    strm[6] = '{1'b0, 16'h0000, 1'b0, 16'hF800, 1'b0, 16'hF800, 1'b0, 16'hF800};

    // en, rin, din | LAT2 r, d   (coef 0x4000)
    stl[0] = '{1'b1, 1'b1, 16'h0100, 1'b0, 16'hF800};
    stl[1] = '{1'b1, 1'b1, 16'h0200, 1'b1, 16'h0080};
    stl[2] = '{1'b0, 1'b1, 16'h0300, 1'b1, 16'h0080};
    stl[3] = '{1'b0, 1'b1, 16'h0300, 1'b1, 16'h0080};
    stl[4] = '{1'b0, 1'b0, 16'h0300, 1'b1, 16'h0080};
    stl[5] = '{1'b1, 1'b1, 16'h0300, 1'b1, 16'h0100};
    stl[6] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0180};
    stl[7] = '{1'b1, 1'b1, 16'h0400, 1'b0, 16'h0180};
    stl[8] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0200};
    stl[9] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0200};

    rst_n = 1'b1; en = 1'b0; r_in = 1'b0; c_we = 1'b0; ovf_clr = 1'b0;
    d_in = '0; c_in = '0;
    #2 rst_n = 1'b0;
    #1 chk_reset("por");
    step();
    step();
    #2 rst_n = 1'b1;
    step();

    // Single-sample vectors; coefficient and OVF clear applied while stalled.
    for (int i = 0; i < 8; i++) begin
      c_we = 1'b1; c_in = vecs[i].coef; ovf_clr = 1'b1; en = 1'b0;
      step();
      c_we = 1'b0; ovf_clr = 1'b0; en = 1'b1; r_in = 1'b1; d_in = vecs[i].din;
      step();
      r_in = 1'b0; d_in = '0;
      repeat (4) step();
      for (int g = 0; g < NDUT; g++) begin
        chk($sformatf("vec%0d_d_dut%0d", i, g), d_out[g], exp_of(vecs[i], g));
        chk($sformatf("vec%0d_ovf_dut%0d", i, g), {15'b0, ovf_o[g]}, {15'b0, vecs[i].ovf});
        chk($sformatf("vec%0d_r_dut%0d", i, g), {15'b0, r_out[g]}, 16'h0);
      end
    end

    // Asynchronous reset mid-cycle clears outputs and the set OVF at once.
    #3 rst_n = 1'b0;
    #1 chk_reset("midrst");
    #1 rst_n = 1'b1;

    // Back-to-back stream after reloading the coefficient.
    c_we = 1'b1; c_in = 16'h4000; en = 1'b0;
    step();
    c_we = 1'b0; en = 1'b1;
    for (int k = 0; k < 7; k++) begin
      r_in = strm[k].rin; d_in = strm[k].din;
      step();
      chk($sformatf("strm%0d_r_lat2", k), {15'b0, r_out[0]}, {15'b0, strm[k].r0});
      chk($sformatf("strm%0d_d_lat2", k), d_out[0], strm[k].d0);
      chk($sformatf("strm%0d_r_lat4", k), {15'b0, r_out[3]}, {15'b0, strm[k].r3});
      chk($sformatf("strm%0d_d_lat4", k), d_out[3], strm[k].d3);
      chk($sformatf("strm%0d_r_lat1", k), {15'b0, r_out[4]}, {15'b0, strm[k].r4});
      chk($sformatf("strm%0d_d_lat1", k), d_out[4], strm[k].d4);
    end

    // Stall and bubbles mid-stream.
    for (int k = 0; k < 10; k++) begin
      en = stl[k].en; r_in = stl[k].rin; d_in = stl[k].din;
      step();
      chk($sformatf("stall%0d_r", k), {15'b0, r_out[0]}, {15'b0, stl[k].r0});
      chk($sformatf("stall%0d_d", k), d_out[0], stl[k].d0);
    end
    en = 1'b1; r_in = 1'b0;
    repeat (3) step();

    // Coefficient write on the same edge as an accept.
    r_in = 1'b1; d_in = 16'h4000; c_we = 1'b1; c_in = 16'h2000;
    step();
    chk("cw_e1_r_lat2", {15'b0, r_out[0]}, 16'h0);
    chk("cw_e1_r_lat1", {15'b0, r_out[4]}, 16'h1);
    chk("cw_e1_d_lat1", d_out[4], 16'h2000);
    chk("cw_e1_r_lat4", {15'b0, r_out[3]}, 16'h0);
    c_we = 1'b0;
    step();
    chk("cw_e2_r_lat2", {15'b0, r_out[0]}, 16'h1);
    chk("cw_e2_d_lat2", d_out[0], 16'h2000);
    chk("cw_e2_d_lat1", d_out[4], 16'h1000);
    chk("cw_e2_r_lat4", {15'b0, r_out[3]}, 16'h0);
    r_in = 1'b0; d_in = '0;
    step();
    chk("cw_e3_d_lat2", d_out[0], 16'h1000);
    chk("cw_e3_r_lat4", {15'b0, r_out[3]}, 16'h0);
    step();
    chk("cw_e4_r_lat2", {15'b0, r_out[0]}, 16'h0);
    chk("cw_e4_r_lat4", {15'b0, r_out[3]}, 16'h1);
    chk("cw_e4_d_lat4", d_out[3], 16'h2000);
    step();

    // OVF clear colliding with an overflowing exit, then clear alone.
    c_we = 1'b1; c_in = 16'h8000; ovf_clr = 1'b1; en = 1'b0;
    step();
    chk("ovf_pre", {15'b0, ovf_o[0]}, 16'h0);
    c_we = 1'b0; ovf_clr = 1'b0; en = 1'b1; r_in = 1'b1; d_in = 16'h8000;
    step();
    chk("ovf_e1", {15'b0, ovf_o[0]}, 16'h0);
    r_in = 1'b0; ovf_clr = 1'b1;
    step();
    chk("ovf_setwins", {15'b0, ovf_o[0]}, 16'h1);
    chk("ovf_sat_d", d_out[0], 16'h7FFF);
    chk("ovf_wrap_d", d_out[2], 16'h8000);
    chk("ovf_wrap_flag", {15'b0, ovf_o[2]}, 16'h1);
    step();
    chk("ovf_clr", {15'b0, ovf_o[0]}, 16'h0);
    ovf_clr = 1'b0;

    // Reset with samples in flight: they must never appear.
    r_in = 1'b1; d_in = 16'h4000;
    step();
    step();
    r_in = 1'b0;
    #3 rst_n = 1'b0;
    #1 chk_reset("flight");
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("flight%0d_r_lat2", k), {15'b0, r_out[0]}, 16'h0);
      chk($sformatf("flight%0d_r_lat4", k), {15'b0, r_out[3]}, 16'h0);
    end
    // Coefficient back to 1: 0x4000 * 1 rounds to 1 LSB.
    r_in = 1'b1; d_in = 16'h4000;
    step();
    r_in = 1'b0;
    step();
    chk("coefI_r", {15'b0, r_out[0]}, 16'h1);
    chk("coefI_d", d_out[0], 16'h0001);
    chk("coefI_d_rnd0", d_out[1], 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
